sr_latch_driver: RTL and testbench

- Clocked front end that drives the S/R inputs of the NOR SR latch (active-high S, R).
- Takes two raw asynchronous push-button inputs and synchronises and debounces them.
- Converts each debounced press into a fixed-width S or R pulse, followed by a mandatory dead time.
- Guarantees the latch never sees the forbidden S=R=1 combination.

---
 rtl/sr_latch_driver.sv | 145 ++++++++++++++
 tb/tb_sr_latch_driver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// Sync/debounce front end producing non-overlapping S/R pulses for a NOR latch.
// Define SR_DRV_INIT_EN to emit one R pulse right after reset release.
module sr_latch_driver #(
  parameter int DB_CYCLES    = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict,
  output logic dropped
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PULSE_S = 2'd1;
  localparam logic [1:0] PULSE_R = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] P_LAST =
    CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] G_LAST =
    CNT_W'(GAP_CYCLES - 1);

  logic [1:0] btn;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] db;
  logic [1:0] req;
  logic [CNT_W-1:0] db_cnt [2];

  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic set_req;
  logic rst_req;

  assign btn     = {rst_btn, set_btn};
  assign set_req = req[0];
  assign rst_req = req[1];
  assign busy    = (state != IDLE);

  // req fires on the same edge db rises, saving a cycle of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      req    <= '0;
      for (int i = 0; i < 2; i++)
        db_cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        req[i] <= 1'b0;
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          db[i]     <= ~db[i];
          req[i]    <= ~db[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef SR_DRV_INIT_EN
  logic init_done;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      S        <= 1'b0;
      R        <= 1'b0;
      conflict <= 1'b0;
      dropped  <= 1'b0;
`ifdef SR_DRV_INIT_EN
      init_done <= 1'b0;
`endif
    end else begin
      conflict <= 1'b0;
      dropped  <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
`ifdef SR_DRV_INIT_EN
          if (!init_done) begin
            init_done <= 1'b1;
            state     <= PULSE_R;
            R         <= 1'b1;
            dropped   <= set_req | rst_req;
          end else
`endif
          if (set_req && rst_req) begin
            conflict <= 1'b1;
          end else if (set_req) begin
            state <= PULSE_S;
            S     <= 1'b1;
          end else if (rst_req) begin
            state <= PULSE_R;
            R     <= 1'b1;
          end
        end
        PULSE_S, PULSE_R: begin
          dropped <= set_req | rst_req;
          if (cnt == P_LAST) begin
            state <= GAP;
            cnt   <= '0;
            S     <= 1'b0;
            R     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          dropped <= set_req | rst_req;
          if (cnt == G_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          S     <= 1'b0;
          R     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural NOR latch downstream.
// Table-driven set press plus hand sequences for the multi-cycle cases.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_btn = 1'b0;
  logic rst_btn = 1'b0;
  logic S, R, busy, conflict, dropped;
  logic q = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic sb;
    logic rb;
    logic s;
    logic r;
    logic bsy;
    logic cf;
    logic dr;
  } vec_t;

  vec_t tbl [14];

  sr_latch_driver dut (
    .clk(clk), .rst_n(rst_n),
    .set_btn(set_btn), .rst_btn(rst_btn),
    .S(S), .R(R), .busy(busy),
    .conflict(conflict), .dropped(dropped)
  );

  always #5 clk = ~clk;

  always @(S or R) begin
    if (S) q = 1'b1;
    else if (R) q = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (S && R) begin
        errors++;
        $display("FAIL s_and_r: S=%0b R=%0b required not both 1", S, R);
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_btn = 1'b0;
    rst_btn = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef SR_DRV_INIT_EN
    step();
    chk("init_r", 8'(R), 8'd1);
    repeat (3) step();
    chk("init_idle", 8'(busy), 8'd0);
`endif
  endtask

  initial begin
    int s_cnt, r_cnt, cf_cnt, dr_cnt, bz_cnt;

    for (int i = 0; i < 14; i++) begin
      tbl[i] = '{sb: 1'b1, rb: 1'b0, s: 1'b0, r: 1'b0,
                 bsy: 1'b0, cf: 1'b0, dr: 1'b0};
    end
    tbl[6].s = 1'b1; tbl[6].bsy = 1'b1;
    tbl[7].s = 1'b1; tbl[7].bsy = 1'b1;
    tbl[8].bsy = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_S", 8'(S), 8'd0);
    chk("rst_R", 8'(R), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_conf", 8'(conflict), 8'd0);
    chk("rst_drop", 8'(dropped), 8'd0);

    // set press: entry i checked after edge i+1
    do_reset();
    for (int i = 0; i < 14; i++) begin
      set_btn = tbl[i].sb;
      rst_btn = tbl[i].rb;
      step();
      chk($sformatf("tbl_S[%0d]", i), 8'(S), 8'(tbl[i].s));
      chk($sformatf("tbl_R[%0d]", i), 8'(R), 8'(tbl[i].r));
      chk($sformatf("tbl_busy[%0d]", i), 8'(busy), 8'(tbl[i].bsy));
      chk($sformatf("tbl_conf[%0d]", i), 8'(conflict), 8'(tbl[i].cf));
      chk($sformatf("tbl_drop[%0d]", i), 8'(dropped), 8'(tbl[i].dr));
    end
    chk("tbl_q", 8'(q), 8'd1);
    set_btn = 1'b0;
    repeat (10) step();
    chk("hold_no_retrig", 8'(busy), 8'd0);

    // bounce rejection
    do_reset();
    s_cnt = 0; cf_cnt = 0; dr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      set_btn = ~set_btn;
      step();
      s_cnt += int'(S); cf_cnt += int'(conflict); dr_cnt += int'(dropped);
    end
    set_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      s_cnt += int'(S); cf_cnt += int'(conflict); dr_cnt += int'(dropped);
    end
    chk("bounce_S", 8'(s_cnt), 8'd0);
    chk("bounce_conf", 8'(cf_cnt), 8'd0);
    chk("bounce_drop", 8'(dr_cnt), 8'd0);

    // set then reset
    do_reset();
    s_cnt = 0; r_cnt = 0;
    set_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      s_cnt += int'(S); r_cnt += int'(R);
    end
    set_btn = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      s_cnt += int'(S); r_cnt += int'(R);
    end
    chk("sr_q_set", 8'(q), 8'd1);
    rst_btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      s_cnt += int'(S); r_cnt += int'(R);
    end
    rst_btn = 1'b0;
    chk("sr_s_cycles", 8'(s_cnt), 8'd2);
    chk("sr_r_cycles", 8'(r_cnt), 8'd2);
    chk("sr_q_reset", 8'(q), 8'd0);
    repeat (10) step();

    // simultaneous press
    do_reset();
    s_cnt = 0; r_cnt = 0; bz_cnt = 0; cf_cnt = 0;
    set_btn = 1'b1;
    rst_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      s_cnt += int'(S); r_cnt += int'(R); bz_cnt += int'(busy);
      cf_cnt += int'(conflict);
      if (i == 7) chk("sim_conf_e7", 8'(conflict), 8'd1);
    end
    chk("sim_conf_cnt", 8'(cf_cnt), 8'd1);
    chk("sim_S", 8'(s_cnt), 8'd0);
    chk("sim_R", 8'(r_cnt), 8'd0);
    chk("sim_busy", 8'(bz_cnt), 8'd0);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    repeat (10) step();

    // press while busy: rst req lands during PULSE_S
    do_reset();
    r_cnt = 0; dr_cnt = 0;
    set_btn = 1'b1;
    step();
    rst_btn = 1'b1;
    for (int i = 2; i <= 20; i++) begin
      step();
      r_cnt += int'(R); dr_cnt += int'(dropped);
      if (i == 8) chk("busy_drop_e8", 8'(dropped), 8'd1);
    end
    chk("busy_drop_cnt", 8'(dr_cnt), 8'd1);
    chk("busy_no_R", 8'(r_cnt), 8'd0);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    repeat (10) step();

    // reset mid-pulse
    do_reset();
    set_btn = 1'b1;
    repeat (7) step();
    chk("mid_S_before", 8'(S), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_S_async", 8'(S), 8'd0);
    chk("mid_busy_async", 8'(busy), 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
`ifdef SR_DRV_INIT_EN
    chk("mid_init_R", 8'(R), 8'd1);
    chk("mid_init_busy", 8'(busy), 8'd1);
`else
    chk("mid_busy_after", 8'(busy), 8'd0);
    chk("mid_R_after", 8'(R), 8'd0);
`endif
    repeat (5) step();
    chk("mid_repress_e6", 8'(S), 8'd0);
    step();
    chk("mid_repress_e7", 8'(S), 8'd1);
    set_btn = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
